// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: GAP/ON slot FSM, one frame-aligned display update per frame.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int GAP_CYC    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [3:0]              bcd_out,
    input  logic [6:0]              seg_in,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_en
);

    localparam int CNT_MAX = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] ON_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic {GAP, ON} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] disp;
    logic [4*NUM_DIGITS-1:0] pend;
    logic                    pend_valid;

    logic [IW-1:0]           nxt_idx;
    logic                    frame_end;
    logic [4*NUM_DIGITS-1:0] disp_next;
    logic [NUM_DIGITS-1:0]   lit;

    assign load_ready = ~pend_valid;
    assign nxt_idx    = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    assign frame_end  = (state == ON) && (cnt == ON_LAST) && (idx == IDX_LAST);
    // Digit 0 of the next frame must come from the value that frame will display.
    assign disp_next  = (frame_end && pend_valid) ? pend : disp;
    // Lit only while an enable is on, so gaps and blanked slots stay dark.
    assign seg_out    = (|dig_en) ? seg_in : 7'd0;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    always_comb begin
        lit = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            lit[k] = (k == 0) || (|(disp >> (4 * k)));
    end
`else
    assign lit = '1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GAP;
            cnt        <= '0;
            idx        <= '0;
            disp       <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            bcd_out    <= 4'd0;
            dig_en     <= '0;
        end else begin
            if (load_valid && !pend_valid) begin
                pend       <= load_data;
                pend_valid <= 1'b1;
            end
            case (state)
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state  <= ON;
                        cnt    <= '0;
                        dig_en <= (NUM_DIGITS'(1) << idx) & lit;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ON: begin
                    if (cnt == ON_LAST) begin
                        state   <= GAP;
                        cnt     <= '0;
                        dig_en  <= '0;
                        idx     <= nxt_idx;
                        bcd_out <= disp_next[{nxt_idx, 2'b00} +: 4];
                        if (frame_end && pend_valid) begin
                            disp       <= pend;
                            pend_valid <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl at NUM_DIGITS=4, SCAN_DIV=4, GAP_CYC=2 (24-cycle frame).
module tb_seg7_scan_ctrl;

    localparam int ND    = 4;
    localparam int FRAME = 24;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = 16'h0;
    logic [3:0]  bcd_out;
    logic [6:0]  seg_in;
    logic [6:0]  seg_out;
    logic [3:0]  dig_en;

    int checks = 0;
    int errors = 0;
    int cyc;

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(4), .GAP_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .bcd_out(bcd_out), .seg_in(seg_in),
        .seg_out(seg_out), .dig_en(dig_en)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0: dec7 = 7'h7E;  4'd1: dec7 = 7'h30;  4'd2: dec7 = 7'h6D;
            4'd3: dec7 = 7'h79;  4'd4: dec7 = 7'h33;  4'd5: dec7 = 7'h5B;
            4'd6: dec7 = 7'h5F;  4'd7: dec7 = 7'h70;  4'd8: dec7 = 7'h7F;
            4'd9: dec7 = 7'h7B;  default: dec7 = 7'h00;
        endcase
    endfunction

    assign seg_in = dec7(bcd_out);

    // Edges since reset release; sampled on negedge, cyc % FRAME is the frame phase.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_t(input int t);
        int n = 0;
        while ((cyc % FRAME) != t && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("wait_timeout", 32'd0, 32'd1);
    endtask

    // Checks one full frame starting at phase 0 against the displayed value and lit mask.
    task automatic chk_frame(input logic [15:0] val, input logic [3:0] mask);
        for (int t = 0; t < FRAME; t++) begin
            int s = t / 6;
            int o = t % 6;
            logic [3:0] ed;
            logic [3:0] eb;
            ed = (o >= 2 && mask[s]) ? (4'b0001 << s) : 4'b0000;
            eb = val[4*s +: 4];
            chk("dig_en", dig_en, ed);
            chk("bcd_out", bcd_out, eb);
            chk("seg_out", seg_out, (ed != 0) ? dec7(eb) : 7'h00);
            @(negedge clk);
        end
    endtask

    task automatic load1(input logic [15:0] d);
        load_valid = 1'b1;
        load_data  = d;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dig_en", dig_en, 4'b0);
        chk("rst_seg_out", seg_out, 7'h0);
        chk("rst_bcd", bcd_out, 4'h0);
        chk("rst_ready", load_ready, 1'b1);
        rst_n = 1'b1;
        chk_frame(16'h0000, LZB ? 4'b0001 : 4'b1111);

        // Mid-frame load appears only from the next frame.
        wait_t(8);
        load1(16'h1234);
        chk("ready_drop", load_ready, 1'b0);
        wait_t(20);
        chk("no_tear_bcd", bcd_out, 4'h0);
        chk("ready_held", load_ready, 1'b0);
        wait_t(0);
        chk("ready_back", load_ready, 1'b1);
        chk_frame(16'h1234, 4'b1111);

        // Second load held while pending full is accepted just after the boundary.
        wait_t(3);
        load_valid = 1'b1;
        load_data  = 16'h0001;
        @(negedge clk);
        load_data  = 16'h0002;
        chk("busy_ready", load_ready, 1'b0);
        wait_t(0);
        chk("bnd_ready", load_ready, 1'b1);
        chk("bnd_bcd", bcd_out, 4'h1);
        @(negedge clk);
        load_valid = 1'b0;
        chk("second_taken", load_ready, 1'b0);
        wait_t(8);
        chk("frame1_d1", dig_en, LZB ? 4'b0000 : 4'b0010);
        wait_t(0);
        chk("ready_after2", load_ready, 1'b1);
        chk_frame(16'h0002, LZB ? 4'b0001 : 4'b1111);

        wait_t(2);
        load1(16'h0007);
        wait_t(0);
        chk_frame(16'h0007, LZB ? 4'b0001 : 4'b1111);

        // Reset during the digit-2 ON slot with a value pending.
        wait_t(5);
        load1(16'h5555);
        wait_t(14);
        chk("pre_rst_dig", dig_en, LZB ? 4'b0000 : 4'b0100);
        chk("pre_rst_ready", load_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dig", dig_en, 4'b0);
        chk("mid_rst_seg", seg_out, 7'h0);
        chk("mid_rst_bcd", bcd_out, 4'h0);
        chk("mid_rst_ready", load_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_frame(16'h0000, LZB ? 4'b0001 : 4'b1111);
        chk_frame(16'h0000, LZB ? 4'b0001 : 4'b1111);

        wait_t(4);
        load1(16'hFA90);
        wait_t(0);
        chk_frame(16'hFA90, 4'b1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of multiplexed digits (legal 2..8).
REQ-002 The block SHALL have parameter SCAN_DIV, default 1000, giving the clock cycles each digit is lit per scan slot (legal >= 2).
REQ-003 The block SHALL have parameter GAP_CYC, default 2, giving the anti-ghosting blank cycles between slots (legal >= 1).
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port load_valid, input, 1, a new display value is offered.
REQ-007 Port load_ready, output, 1, the block can accept a value.
REQ-008 Port load_data, input, 4*NUM_DIGITS, BCD digits, where digit k = load_data[4k+3:4k] and digit 0 is least significant.
REQ-009 Port bcd_out, output, 4, the digit code driven to the external BCD-to-7-segment decoder.
REQ-010 Port seg_in, input, 7, the decoder result {a,b,c,d,e,f,g}, active high.
REQ-011 Port seg_out, output, 7, the segment drive to the display, active high.
REQ-012 Port dig_en, output, NUM_DIGITS, the digit enables, active high, one-hot or zero.

Function
REQ-013 The block SHALL implement a two-state FSM, GAP and ON, with a slot counter sized $clog2(max(SCAN_DIV,GAP_CYC)) and a digit index idx.
REQ-014 In GAP, dig_en SHALL be 0 and seg_out SHALL be 0; after GAP_CYC cycles the FSM SHALL enter ON with the counter cleared.
REQ-015 In ON, dig_en SHALL be one-hot at bit idx and seg_out SHALL equal seg_in; after SCAN_DIV cycles the FSM SHALL enter GAP with the counter cleared.
REQ-016 On each ON->GAP transition, idx SHALL advance by 1 and wrap from NUM_DIGITS-1 to 0.
REQ-017 On the same ON->GAP transition, bcd_out SHALL be registered with the digit for the new idx, so the decoder settles during GAP.
REQ-018 Handshake: a transfer SHALL occur when load_valid and load_ready are both 1 on a rising edge; load_ready SHALL equal NOT pending_valid.
REQ-019 On a transfer, the block SHALL store load_data in a pending register and set pending_valid.
REQ-020 At the frame boundary (ON->GAP with idx = NUM_DIGITS-1), if pending_valid is set, the display register SHALL take the pending value and pending_valid SHALL clear. bcd_out for digit 0 SHALL then use the new value, so a frame is never torn.
REQ-021 A transfer in the same cycle as a boundary that found the pending register empty SHALL land in pending and be displayed from the following frame.
REQ-022 Digit codes 10..15 SHALL pass unchanged to bcd_out; blanking them is the decoder's responsibility.
REQ-023 Frame period SHALL be exactly NUM_DIGITS*(SCAN_DIV+GAP_CYC) cycles, and load traffic SHALL NOT alter scan timing.

Reset
REQ-024 While rst_n = 0, the block SHALL force: FSM in GAP, counter 0, idx 0, display register 0, pending register 0, pending_valid 0, bcd_out 0, seg_out 0, dig_en 0, load_ready 1.
REQ-025 After rst_n deasserts, the first ON slot SHALL lights digit 0 after GAP_CYC cycles.
REQ-026 Reset asserted mid-slot or mid-handshake SHALL discard any pending value with no partial update.

Configuration
REQ-027 When macro SEG7_LEADING_ZERO_BLANK_EN is defined, each digit above the most significant nonzero digit of the display register SHALL have dig_en 0 and seg_out 0 during its ON slot; digit 0 SHALL never be blanked and slot timing SHALL be unchanged.
REQ-028 When SEG7_LEADING_ZERO_BLANK_EN is undefined, all digits SHALL be lit, including leading zeros.

Verification (NUM_DIGITS=4, SCAN_DIV=4, GAP_CYC=2, frame = 24 cycles)
REQ-029 Reset release -> dig_en=0000 for 2 cycles, then 0001 for 4 cycles, 2 gap cycles, then 0010; seg_out=0 in every gap.
REQ-030 Load 16'h1234 mid-frame -> load_ready drops next cycle; display register unchanged until idx-3 slot ends; next frame bcd_out sequence is 4,3,2,1; load_ready returns 1 at that boundary.
REQ-031 Load 16'h0001, then 16'h0002 held while load_ready=0 -> the second load is accepted the cycle after the boundary and displayed one frame later.
REQ-032 Load 16'h0007 with SEG7_LEADING_ZERO_BLANK_EN defined -> only the digit-0 slot asserts dig_en (0001); the other slots show 0000 with unchanged timing. Without the macro, all four slots are lit and bcd_out sequence is 7,0,0,0.
REQ-033 rst_n pulsed low during ON of digit 2 with pending_valid=1 -> all outputs go to reset values immediately, pending is dropped, and the restart matches REQ-029.
REQ-034 Load 16'hFA90 -> bcd_out presents 0,9,A,F unchanged; seg_out mirrors seg_in during ON.
